chipper_ni: RTL and testbench
=============================

Name: chipper_ni

Overview:
- Processing-element network interface for one 3D CHIPPER node; the PE-side counterpart of the router's injection/ejection port.
- TX path: buffers core requests, builds 32-bit flits, drives the router's PE input with an inject request, and pops on inject grant.
- RX path: captures flits the router ejects on its PE output and presents them to the core through a small buffer.
- Ages stalled TX flits so that they are eventually marked golden.

Parameters:
- xn, 2'b00, X coordinate of this node
- yn, 2'b00, Y coordinate of this node
- zn, 2'b00, Z coordinate of this node
- TX_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- GOLD_AGE, 8, stall cycles before the TX head is promoted to golden

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  core has a flit request
- tx_ready  out  1  TX FIFO not full
- tx_dst  in  6  destination {x[1:0],y[1:0],z[1:0]}
- tx_data  in  24  payload
- pein  out  32  flit to router PE input
- inject_request  out  1  to router
- inject_grant  in  1  from router, same cycle as request
- peout  in  32  ejected flit from router (all-zero = none)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  core accepts RX head
- rx_src_dst  out  6  destination field of RX head
- rx_data  out  24  payload of RX head
- rx_golden  out  1  golden bit of RX head
- rx_overflow  out  1  sticky: ejected flit dropped because RX FIFO was full

Behaviour:
- Flit format: [31:30] X, [29:28] Y, [27:26] Z, [25] golden, [24] valid marker (always 1 on built flits), [23:0] payload. Valid marker guarantees a nonzero flit.
- Reset: both FIFOs empty, age counter 0, rx_overflow 0, pein 0, inject_request 0, rx_valid 0, tx_ready 1.
- TX push on tx_valid && tx_ready. FIFO is first-word-fall-through. Push and pop in the same cycle are legal when full: tx_ready is based on registered count, so a full FIFO does not accept a push even if it pops.
- inject_request = TX non-empty and head destination ≠ (xn,yn,zn). pein = head flit with golden bit OR'd in; pein = 0 when there is no request.
- Pop the TX head on the clock edge where inject_request && inject_grant.
- Loopback: if head destination == own coordinates, the flit is not injected. It is written to the RX FIFO instead, in a cycle with no ejection (peout == 0) and RX not full; otherwise it waits.
- Age counter: counts cycles with inject_request=1 && inject_grant=0, saturating at GOLD_AGE. It clears on pop. Head is golden while counter == GOLD_AGE.
- RX push when peout[24]==1. Flits with peout nonzero but bit24==0 are ignored.
- RX full at push: flit dropped, rx_overflow set (cleared only by rst). Ejection never stalls, because the router cannot be backpressured.
- RX pop on rx_valid && rx_ready. RX push and pop in the same cycle are allowed at any occupancy; full with a simultaneous pop does not drop.
- Latency: peout to rx_valid is 1 cycle; tx push to inject_request is 1 cycle.
- Reset mid-operation: all buffered flits are discarded and no request is issued in the cycle after reset.

Optional Feature:
- CHIPPER_NI_GOLDEN_EN defined: golden promotion as above, and rx_golden reflects bit25.
- Not defined: no age counter, bit25 always 0 on injected flits, rx_golden tied 0, GOLD_AGE unused.

Decomposition:
- Package chipper_ni_pkg holds:
  - flit field bit-position constants (X_HI..PAYLOAD_LO, GOLD_BIT=25, VALID_BIT=24);
  - FLIT_W=32, PAYLOAD_W=24;
  - the empty-flit constant.
- One sub-module, chipper_ni_fifo (parameterised width/depth, FWFT, count output), instantiated for TX and RX.

Test Plan:
- Node (1,1,0): push dst=6'b10_01_00, data=24'hABCDEF with grant held 1 → next cycle inject_request=1, pein=32'h91ABCDEF, entry popped, inject_request=0 the cycle after.
- Grant held 0 for 8 cycles with CHIPPER_NI_GOLDEN_EN → pein[25]=1 from the 9th request cycle. Grant then asserted → pop and age counter back to 0. Without the macro, pein[25] stays 0.
- Push 4 flits with grant=0 → tx_ready=0 after the 4th, 5th push ignored. Assert grant for 4 cycles → FIFO order preserved, tx_ready returns to 1.
- peout=32'h05000123 (bit24=1) → next cycle rx_valid=1, rx_data=24'h000123. peout=32'h00000123 → ignored.
- RX full, rx_ready=0, peout valid → flit dropped, rx_overflow=1 and stays 1. Same scenario with rx_ready=1 → no drop.
- Node (0,0,0): push a flit with dst=0 while peout is valid → no inject_request, loopback delayed one cycle. RX then holds the ejected flit, then the loopback flit.

Source files
------------

// File: rtl/chipper_ni_pkg.sv
// Shared flit layout, widths and helpers for the CHIPPER PE network interface.
package chipper_ni_pkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned DST_W     = 6;

  localparam int unsigned X_HI       = 31;
  localparam int unsigned X_LO       = 30;
  localparam int unsigned Y_HI       = 29;
  localparam int unsigned Y_LO       = 28;
  localparam int unsigned Z_HI       = 27;
  localparam int unsigned Z_LO       = 26;
  localparam int unsigned GOLD_BIT   = 25;
  localparam int unsigned VALID_BIT  = 24;
  localparam int unsigned PAYLOAD_HI = 23;
  localparam int unsigned PAYLOAD_LO = 0;

  localparam logic [FLIT_W-1:0] EMPTY_FLIT = '0;

  typedef struct packed {
    logic [DST_W-1:0]     dst;
    logic [PAYLOAD_W-1:0] payload;
  } tx_req_t;

  // Assemble a flit; the valid marker keeps every built flit nonzero.
  function automatic logic [FLIT_W-1:0] build_flit(input logic [DST_W-1:0]     dst,
                                                   input logic                 golden,
                                                   input logic [PAYLOAD_W-1:0] payload);
    logic [FLIT_W-1:0] f;
    f                       = EMPTY_FLIT;
    f[X_HI:X_LO]            = dst[5:4];
    f[Y_HI:Y_LO]            = dst[3:2];
    f[Z_HI:Z_LO]            = dst[1:0];
    f[GOLD_BIT]             = golden;
    f[VALID_BIT]            = 1'b1;
    f[PAYLOAD_HI:PAYLOAD_LO] = payload;
    return f;
  endfunction

endpackage

// File: rtl/chipper_ni_fifo.sv
// First-word-fall-through FIFO with occupancy count; callers only push/pop when legal.
module chipper_ni_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/chipper_ni.sv
// PE network interface for a 3D CHIPPER node: TX inject path, RX eject path, local loopback.
// Golden aging of the TX head is built only with CHIPPER_NI_GOLDEN_EN defined.
module chipper_ni
  import chipper_ni_pkg::*;
#(
  parameter logic [1:0]  xn       = 2'b00,
  parameter logic [1:0]  yn       = 2'b00,
  parameter logic [1:0]  zn       = 2'b00,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned GOLD_AGE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [5:0]  tx_dst,
  input  logic [23:0] tx_data,
  output logic [31:0] pein,
  output logic        inject_request,
  input  logic        inject_grant,
  input  logic [31:0] peout,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [5:0]  rx_src_dst,
  output logic [23:0] rx_data,
  output logic        rx_golden,
  output logic        rx_overflow
);

  localparam logic [DST_W-1:0] OWN   = {xn, yn, zn};
  localparam int unsigned      TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned      RX_CW = $clog2(RX_DEPTH) + 1;

  tx_req_t           tx_wdata;
  tx_req_t           tx_head;
  logic [TX_CW-1:0]  tx_count;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_nonempty;
  logic              tx_local;
  logic              head_golden;

  logic [FLIT_W-1:0] rx_wdata;
  logic [FLIT_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic              eject;
  logic              loop_fire;

  // TX side
  assign tx_ready    = (tx_count != TX_CW'(TX_DEPTH));
  assign tx_push     = tx_valid && tx_ready;
  assign tx_wdata    = '{dst: tx_dst, payload: tx_data};
  assign tx_nonempty = (tx_count != '0);
  assign tx_local    = tx_nonempty && (tx_head.dst == OWN);

  assign inject_request = tx_nonempty && !tx_local;
  assign pein = inject_request ? build_flit(tx_head.dst, head_golden, tx_head.payload)
                               : EMPTY_FLIT;

  // Loopback only uses the RX write port when the router is not ejecting.
  assign loop_fire = tx_local && (peout == EMPTY_FLIT) && !rx_full;
  assign tx_pop    = (inject_request && inject_grant) || loop_fire;

  chipper_ni_fifo #(
    .W     ($bits(tx_req_t)),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (tx_wdata),
    .rdata (tx_head),
    .count (tx_count)
  );

`ifdef CHIPPER_NI_GOLDEN_EN
  localparam int unsigned AGE_W = $clog2(GOLD_AGE + 1);

  logic [AGE_W-1:0] age;

  assign head_golden = (age == AGE_W'(GOLD_AGE));

  // Count stalled request cycles, saturating once the head turns golden.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (tx_pop) begin
      age <= '0;
    end else if (inject_request && !inject_grant && !head_golden) begin
      age <= age + AGE_W'(1);
    end
  end

  assign rx_golden = rx_head[GOLD_BIT];
`else
  assign head_golden = 1'b0;
  assign rx_golden   = 1'b0;
`endif

  // RX side
  assign eject    = peout[VALID_BIT];
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_push  = (eject || loop_fire) && (!rx_full || rx_pop);
  assign rx_wdata = eject ? peout : build_flit(tx_head.dst, 1'b0, tx_head.payload);

  chipper_ni_fifo #(
    .W     (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_wdata),
    .rdata (rx_head),
    .count (rx_count)
  );

  assign rx_src_dst = {rx_head[X_HI:X_LO], rx_head[Y_HI:Y_LO], rx_head[Z_HI:Z_LO]};
  assign rx_data    = rx_head[PAYLOAD_HI:PAYLOAD_LO];

  // Sticky drop flag: the router cannot be stalled, so a full RX loses the flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
    end else if (eject && rx_full && !rx_pop) begin
      rx_overflow <= 1'b1;
    end
  end

  logic unused_bits;
`ifdef CHIPPER_NI_GOLDEN_EN
  assign unused_bits = rx_head[VALID_BIT];
`else
  assign unused_bits = ^{rx_head[VALID_BIT], rx_head[GOLD_BIT], GOLD_AGE != 0};
`endif

endmodule

// File: tb/tb_chipper_ni.sv
// Directed self-checking bench for chipper_ni at node (1,1,0).
module tb_chipper_ni;

`ifdef CHIPPER_NI_GOLDEN_EN
  localparam logic GOLD_EXP = 1'b1;
`else
  localparam logic GOLD_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [5:0]  tx_dst;
  logic [23:0] tx_data;
  logic [31:0] pein;
  logic        inject_request;
  logic        inject_grant;
  logic [31:0] peout;
  logic        rx_valid;
  logic        rx_ready;
  logic [5:0]  rx_src_dst;
  logic [23:0] rx_data;
  logic        rx_golden;
  logic        rx_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chipper_ni #(
    .xn       (2'b01),
    .yn       (2'b01),
    .zn       (2'b00),
    .TX_DEPTH (4),
    .RX_DEPTH (4),
    .GOLD_AGE (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_dst         (tx_dst),
    .tx_data        (tx_data),
    .pein           (pein),
    .inject_request (inject_request),
    .inject_grant   (inject_grant),
    .peout          (peout),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_src_dst     (rx_src_dst),
    .rx_data        (rx_data),
    .rx_golden      (rx_golden),
    .rx_overflow    (rx_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  initial begin
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_dst       = 6'b10_01_00;
    tx_data      = '0;
    inject_grant = 1'b0;
    peout        = '0;
    rx_ready     = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_inject_request", 32'(inject_request), 32'd0);
    chk("rst_pein", pein, 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_overflow", 32'(rx_overflow), 32'd0);

    // Basic injection with grant held high
    inject_grant = 1'b1;
    tx_valid     = 1'b1;
    tx_dst       = 6'b10_01_00;
    tx_data      = 24'hABCDEF;
    step();
    tx_valid = 1'b0;
    chk("inj_request", 32'(inject_request), 32'd1);
    chk("inj_pein", pein, 32'h91ABCDEF);
    step();
    chk("inj_popped_request", 32'(inject_request), 32'd0);
    chk("inj_popped_pein", pein, 32'h0);

    // Aging under a held-off grant
    inject_grant = 1'b0;
    tx_valid     = 1'b1;
    tx_data      = 24'h000055;
    step();
    tx_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("age_not_golden", pein, 32'h91000055);
      step();
    end
    chk("age_golden", pein, GOLD_EXP ? 32'h93000055 : 32'h91000055);
    inject_grant = 1'b1;
    step();
    chk("age_pop_request", 32'(inject_request), 32'd0);
    inject_grant = 1'b0;
    tx_valid     = 1'b1;
    tx_data      = 24'h000066;
    step();
    tx_valid = 1'b0;
    chk("age_cleared", pein, 32'h91000066);
    inject_grant = 1'b1;
    step();
    inject_grant = 1'b0;
    chk("age_cleared_pop", 32'(inject_request), 32'd0);

    // TX fill, overflowing push ignored, drain in order
    tx_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tx_data = 24'(i);
      step();
    end
    chk("txfull_ready", 32'(tx_ready), 32'd0);
    tx_data = 24'h000005;
    step();
    tx_valid = 1'b0;
    chk("txfull_ready_hold", 32'(tx_ready), 32'd0);
    inject_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("txfull_order", pein, 32'h91000000 + 32'(i));
      step();
    end
    inject_grant = 1'b0;
    chk("txfull_drained", 32'(inject_request), 32'd0);
    chk("txfull_ready_back", 32'(tx_ready), 32'd1);

    // RX capture, invalid-marker flit ignored
    peout = 32'h05000123;
    step();
    peout = 32'h0;
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'h000123);
    chk("rx_src_dst", 32'(rx_src_dst), 32'h01);
    peout = 32'h00000123;
    step();
    peout    = 32'h0;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_ignore_novalid", 32'(rx_valid), 32'd0);
    peout = 32'h07000456;
    step();
    peout = 32'h0;
    chk("rx_golden", 32'(rx_golden), 32'(GOLD_EXP));
    chk("rx_golden_data", 32'(rx_data), 32'h000456);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_golden_popped", 32'(rx_valid), 32'd0);

    // RX overflow drop
    for (int i = 0; i < 4; i++) begin
      peout = 32'h01000010 + 32'(i);
      step();
    end
    peout = 32'h010000FF;
    step();
    peout = 32'h0;
    chk("ovf_set", 32'(rx_overflow), 32'd1);
    step();
    chk("ovf_sticky", 32'(rx_overflow), 32'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", 32'(rx_data), 32'h10 + 32'(i));
      step();
    end
    rx_ready = 1'b0;
    chk("ovf_dropped", 32'(rx_valid), 32'd0);
    chk("ovf_sticky_after", 32'(rx_overflow), 32'd1);

    // Full RX with simultaneous pop keeps the ejected flit
    for (int i = 0; i < 4; i++) begin
      peout = 32'h01000020 + 32'(i);
      step();
    end
    rx_ready = 1'b1;
    peout    = 32'h010000EE;
    step();
    peout = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      chk("fullpop_order", 32'(rx_data), 32'h20 + 32'(i));
      step();
    end
    chk("fullpop_kept", 32'(rx_data), 32'h0000EE);
    step();
    rx_ready = 1'b0;
    chk("fullpop_empty", 32'(rx_valid), 32'd0);

    // Loopback to own node, deferred behind an ejection
    tx_valid = 1'b1;
    tx_dst   = 6'b01_01_00;
    tx_data  = 24'h0000AA;
    step();
    tx_valid = 1'b0;
    peout    = 32'h01000BBB;
    chk("loop_no_request", 32'(inject_request), 32'd0);
    chk("loop_no_pein", pein, 32'h0);
    step();
    peout = 32'h0;
    chk("loop_eject_first", 32'(rx_data), 32'h000BBB);
    step();
    rx_ready = 1'b1;
    chk("loop_head_eject", 32'(rx_data), 32'h000BBB);
    step();
    chk("loop_data", 32'(rx_data), 32'h0000AA);
    chk("loop_dst", 32'(rx_src_dst), 32'h14);
    chk("loop_golden", 32'(rx_golden), 32'd0);
    step();
    rx_ready = 1'b0;
    chk("loop_rx_empty", 32'(rx_valid), 32'd0);
    chk("loop_tx_idle", 32'(inject_request), 32'd0);

    // Reset in the middle of traffic
    tx_valid = 1'b1;
    tx_dst   = 6'b10_01_00;
    tx_data  = 24'h000077;
    peout    = 32'h01000099;
    step();
    step();
    tx_valid = 1'b0;
    peout    = 32'h0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_request", 32'(inject_request), 32'd0);
    chk("mid_rst_pein", pein, 32'h0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_overflow", 32'(rx_overflow), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
